// File: rtl/uart_tx_buffered_if.sv
// Push-side bundle for the buffered UART transmitter.
// The master writes bytes; the slave reports FIFO occupancy.
interface uart_tx_buffered_if;
  logic       writeFlag;
  logic [7:0] dataToSend;
  logic       fullFlag;
  logic       emptyFlag;

  modport master (
    output writeFlag,
    output dataToSend,
    input  fullFlag,
    input  emptyFlag
  );

  modport slave (
    input  writeFlag,
    input  dataToSend,
    output fullFlag,
    output emptyFlag
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a circular byte FIFO.
// Frames are sent back to back while the FIFO has data.
module uart_tx_buffered #(
  parameter int BIT_COUNT  = 10416,
  parameter int DEPTH_BITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  uart_tx_buffered_if.slave   bus,
  output logic                uart_tx,
  output logic                txBusy,
  output logic                uart_tx_done
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CW    = DEPTH_BITS + 1;
  localparam int TW    = $clog2(BIT_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    head;
  logic          push;
  logic          pop;
  logic          wrap;

  assign bus.fullFlag  = count == CW'(DEPTH);
  assign bus.emptyFlag = count == '0;
  assign wrap = timer == TW'(BIT_COUNT - 1);
  assign push = bus.writeFlag && !bus.fullFlag;
  assign head = mem[rd_ptr[DEPTH_BITS-1:0]];

  // The next byte is taken when idle or right at the stop-bit wrap.
  assign pop = !bus.emptyFlag &&
    ((state == IDLE) || (state == STOP && wrap));

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr[DEPTH_BITS-1:0]] <= bus.dataToSend;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == CW'(DEPTH - 1))
          ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == CW'(DEPTH - 1))
          ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      uart_tx      <= 1'b1;
      txBusy       <= 1'b0;
      uart_tx_done <= 1'b0;
      timer        <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
    end else begin
      uart_tx_done <= 1'b0;
      timer <= (state == IDLE || wrap)
        ? '0 : timer + 1'b1;
      unique case (state)
        IDLE: begin
          if (pop) begin
            state   <= START;
            shreg   <= head;
            bit_idx <= '0;
            uart_tx <= 1'b0;
            txBusy  <= 1'b1;
          end
        end
        START: begin
          if (wrap) begin
            state   <= DATA;
            uart_tx <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        DATA: begin
          if (wrap) begin
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              uart_tx <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        STOP: begin
          if (wrap) begin
            uart_tx_done <= 1'b1;
            if (pop) begin
              state   <= START;
              shreg   <= head;
              bit_idx <= '0;
              uart_tx <= 1'b0;
            end else begin
              state  <= IDLE;
              txBusy <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: frame-level model,
// line receiver and directed plus random traffic.
module tb_uart_tx_buffered;
  localparam int BC    = 16;
  localparam int DB    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * BC;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic uart_tx;
  logic txBusy;
  logic uart_tx_done;

  uart_tx_buffered_if bus ();

  uart_tx_buffered #(
    .BIT_COUNT (BC),
    .DEPTH_BITS(DB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .uart_tx     (uart_tx),
    .txBusy      (txBusy),
    .uart_tx_done(uart_tx_done)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  // Frame-level reference: a byte queue plus the
  // number of cycles left in the frame on the line.
  logic [7:0] fq[$];
  logic [7:0] sent[$];
  logic [7:0] rx[$];
  bit         m_busy = 0;
  bit         m_done = 0;
  int         rem = 0;
  logic [7:0] m_byte = '0;
  bit         ending, pop_now, push_ok;
  int         cyc = 0;

  always @(posedge clock) cyc++;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      fq.delete();
      m_busy = 0;
      m_done = 0;
      rem = 0;
    end else begin
      ending  = m_busy && rem == 1;
      pop_now = fq.size() != 0 && (!m_busy || ending);
      push_ok = bus.writeFlag && fq.size() < DEPTH;
      m_done  = ending;
      if (ending) begin
        sent.push_back(m_byte);
        m_busy = 0;
      end else if (m_busy) rem--;
      if (pop_now) begin
        m_byte = fq.pop_front();
        m_busy = 1;
        rem = FRAME;
      end
      if (push_ok) fq.push_back(bus.dataToSend);
    end
  end

  function automatic logic exp_tx();
    int b;
    if (!m_busy) return 1'b1;
    b = (FRAME - rem) / BC;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  bit         rx_on = 0;
  int         t_start = 0;
  int         ph;
  logic [7:0] rx_byte = '0;

  always @(negedge clock) begin
    chk("tx", uart_tx, exp_tx());
    chk("busy", txBusy, m_busy);
    chk("done", uart_tx_done, m_done);
    chk("empty", bus.emptyFlag, fq.size() == 0);
    chk("full", bus.fullFlag, fq.size() == DEPTH);
    if (!reset) rx_on = 0;
    else begin
      if (uart_tx_done)
        chk("frame_len", cyc - t_start, FRAME);
      if (!rx_on) begin
        if (!uart_tx) begin
          rx_on = 1;
          t_start = cyc;
        end
      end else begin
        ph = cyc - t_start;
        if (ph >= 24 && ph <= 136 && ph % 16 == 8)
          rx_byte[(ph-24)/16] = uart_tx;
        if (ph == 152) begin
          chk("stop_bit", uart_tx, 1);
          rx.push_back(rx_byte);
          rx_on = 0;
        end
      end
    end
  end

  task automatic push(input logic [7:0] d);
    bus.writeFlag  = 1'b1;
    bus.dataToSend = d;
    @(negedge clock);
    bus.writeFlag  = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int k = 0;
    while ((m_busy || fq.size() != 0) && k < limit) begin
      @(negedge clock);
      k++;
    end
    repeat (2) @(negedge clock);
    chk("drain_timeout", k < limit, 1);
  endtask

  int n0;
  int lows;
  int dones;
  int rate;

  initial begin
    bus.writeFlag  = 1'b0;
    bus.dataToSend = '0;
    repeat (3) @(negedge clock);
    chk("rst_tx", uart_tx, 1);
    chk("rst_empty", bus.emptyFlag, 1);
    chk("rst_full", bus.fullFlag, 0);
    chk("rst_busy", txBusy, 0);
    reset = 1'b1;

    // single byte, first edge after release
    push(8'h55);
    chk("pre_start_tx", uart_tx, 1);
    @(negedge clock);
    chk("latency_tx", uart_tx, 0);
    wait_drain(400);
    chk("b55_cnt", rx.size(), 1);
    chk("b55", rx[0], 8'h55);

    // back-to-back pair
    push(8'hA3);
    push(8'h0F);
    wait_drain(800);
    chk("pair_cnt", rx.size(), 3);
    chk("pair0", rx[1], 8'hA3);
    chk("pair1", rx[2], 8'h0F);

    // overfill, then push against a pop while full
    n0 = rx.size();
    for (int i = 1; i <= 6; i++) push(8'(i));
    chk("full6", bus.fullFlag, 1);
    bus.writeFlag  = 1'b1;
    bus.dataToSend = 8'hEE;
    repeat (200) begin
      @(negedge clock);
      if (uart_tx_done)
        chk("drop_on_pop", bus.fullFlag, 0);
    end
    bus.writeFlag = 1'b0;
    wait_drain(2000);
    chk("fill_cnt", rx.size(), n0 + 6);
    for (int i = 0; i < 5; i++)
      chk("fill_order", rx[n0+i], 8'(i + 1));
    chk("fill_tail", rx[n0+5], 8'hEE);

    // reset in the middle of a frame
    n0 = rx.size();
    push(8'hFF);
    push(8'h11);
    push(8'h22);
    repeat (67) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("abort_tx", uart_tx, 1);
    chk("abort_empty", bus.emptyFlag, 1);
    chk("abort_busy", txBusy, 0);
    chk("abort_done", uart_tx_done, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    lows = 0;
    dones = 0;
    repeat (500) begin
      @(negedge clock);
      if (!uart_tx) lows++;
      if (uart_tx_done) dones++;
    end
    chk("quiet_low", lows, 0);
    chk("quiet_done", dones, 0);
    chk("quiet_rx", rx.size(), n0);

    // random traffic with varying push rate
    rate = 2;
    for (int c = 0; c < 6000; c++) begin
      if (c % 500 == 0) rate = $urandom_range(1, 6);
      bus.writeFlag  = $urandom_range(0, 99) < rate;
      bus.dataToSend = 8'($urandom);
      @(negedge clock);
    end
    bus.writeFlag = 1'b0;
    wait_drain(2000);

    chk("rx_count", rx.size(), sent.size());
    for (int i = 0; i < rx.size() && i < sent.size(); i++)
      chk("rx_byte", rx[i], sent[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter BIT_COUNT, default 10416, clock cycles per serial bit (651*16 at the system clock).
REQ-002 Parameter DEPTH_BITS, default 4, log2 of FIFO depth (16 entries).
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 writeFlag  input  1  push request; qualifies dataToSend for one cycle.
REQ-006 dataToSend  input  8  byte to enqueue.
REQ-007 fullFlag  output  1  high when the FIFO holds 2^DEPTH_BITS bytes.
REQ-008 emptyFlag  output  1  high when the FIFO holds 0 bytes.
REQ-009 uart_tx  output  1  serial line, 8N1, idle high, registered.
REQ-010 txBusy  output  1  high while a frame is in progress (state != IDLE).
REQ-011 uart_tx_done  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-012 FIFO SHALL be circular, with write pointer, read pointer and occupancy count of width DEPTH_BITS+1; pointers wrap from 2^DEPTH_BITS-1 to 0.
REQ-013 A push with writeFlag=1 and fullFlag=0 SHALL store dataToSend and increment the count at the same edge; a push while fullFlag=1 SHALL be dropped with no state change, even if a pop occurs that cycle.
REQ-014 A simultaneous push (not full) and pop SHALL leave the count unchanged and advance both pointers.
REQ-015 fullFlag/emptyFlag SHALL be derived from the registered count, so they update one cycle after the causing edge.
REQ-016 FSM states: IDLE, START, DATA, STOP.
REQ-017 IDLE: when emptyFlag=0 at an edge, go to START, load the FIFO head into the shift register, pop it, clear the bit timer and bit index, and drive uart_tx=0.
REQ-018 Bit timer SHALL count 0..BIT_COUNT-1; every line level SHALL be held for exactly BIT_COUNT cycles.
REQ-019 START -> DATA at timer wrap; DATA SHALL shift LSB first, bit index 0..7, advancing one bit per timer wrap.
REQ-020 DATA -> STOP after bit 7 completes; STOP SHALL drive uart_tx=1 for BIT_COUNT cycles.
REQ-021 At the STOP timer wrap, uart_tx_done SHALL pulse for exactly one cycle.
REQ-021a At that same edge, if emptyFlag=0 the FSM SHALL enter START directly, popping the next byte with no idle gap; otherwise it SHALL enter IDLE.
REQ-022 Frame length SHALL be exactly 10*BIT_COUNT cycles.
REQ-022a Latency: a push into an empty, idle block at edge k SHALL drive uart_tx low from edge k+1.
REQ-023 Pushes during a frame SHALL NOT disturb the byte being shifted.
REQ-024 uart_tx SHALL come from a flop, with no combinational path from any input.

Reset
REQ-025 Assertion (reset=0) SHALL immediately force: uart_tx=1, txBusy=0, uart_tx_done=0, state IDLE, pointers/count/timer/index=0, emptyFlag=1, fullFlag=0.
REQ-026 Reset mid-frame SHALL abort the frame and flush the FIFO; no residual bits are sent after release.
REQ-027 The first push is accepted at the first rising edge after reset deasserts.

Verification (BIT_COUNT=16, DEPTH_BITS=2)
REQ-028 Push 0x55 once -> uart_tx low at edge k+1, then bits 1,0,1,0,1,0,1,0, then high; each level lasts 16 cycles; uart_tx_done pulses 160 cycles after the start edge; emptyFlag=1 afterwards.
REQ-029 Push 0xA3, 0x0F on consecutive cycles -> two back-to-back frames of 320 cycles total with no idle cycle between them; two uart_tx_done pulses, 160 cycles apart.
REQ-030 Push 6 bytes 0x01..0x06 on consecutive cycles -> first byte popped into the shifter; FIFO fills at 4; fullFlag=1; the 6th push is dropped; 0x01..0x05 are transmitted in order.
REQ-031 Push while full in the same cycle as a pop -> push dropped; count decrements by 1.
REQ-032 Assert reset at cycle 70 of a 0xFF frame with 2 bytes queued -> uart_tx=1 immediately; emptyFlag=1; line stays high with no uart_tx_done pulse for 500 cycles after release.
REQ-033 Continuous random traffic -> scoreboard: received byte stream equals accepted pushes, and no frame is shorter or longer than 160 cycles.
